// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the EXE stage.
// Radix-2 shift-add multiply and restoring divide; fixed latency of WIDTH+2 cycles to done.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic [1:0]       op_r;
  logic             sign_a_r, sign_b_r, b_zero_r;
  logic [WIDTH-1:0] mag_b_r, rem_r, quo_r, hi_r, lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, done_r;

  logic             launch_s, mreg_we_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [WIDTH-1:0] iter_rem_s, iter_quo_s, fix_hi_s, fix_lo_s;
  logic [PW-1:0]    prod_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
    return ~v + PW'(1);
  endfunction

  // Signed ops (op[0]==0) work on magnitudes; unsigned ops take the raw value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return neg_w(v);
    end else begin
      return v;
    end
  endfunction

  assign launch_s  = (state_r == IDLE) && start && !flush;
  assign mreg_we_s = (state_r == IDLE) && !start;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_next_s = CALC;
        else          state_next_s = IDLE;
      end
      CALC: begin
        if (flush)                   state_next_s = IDLE;
        else if (cnt_r == LAST_ITER) state_next_s = FIX;
        else                         state_next_s = CALC;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // One radix-2 step: rem_r:quo_r is the product register or remainder:dividend pair.
  always_comb begin
    mul_sum_s   = {1'b0, rem_r} + (quo_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mag_b_r};
    iter_rem_s  = rem_r;
    iter_quo_s  = quo_r;
    if (op_r[1]) begin
      if (!div_diff_s[WIDTH]) begin
        iter_rem_s = div_diff_s[WIDTH-1:0];
        iter_quo_s = {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        iter_rem_s = div_shift_s[WIDTH-1:0];
        iter_quo_s = {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_rem_s = mul_sum_s[WIDTH:1];
      iter_quo_s = {mul_sum_s[0], quo_r[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the FIX edge.
  always_comb begin
    prod_s   = {rem_r, quo_r};
    fix_hi_s = rem_r;
    fix_lo_s = quo_r;
    if (op_r[1]) begin
      // Remainder of a zero divisor is the dividend itself, so only LO needs overriding.
      if (b_zero_r)                          fix_lo_s = ALL_ONES;
      else if (!op_r[0] && (sign_a_r ^ sign_b_r)) fix_lo_s = neg_w(quo_r);
      else                                   fix_lo_s = quo_r;
      if (!op_r[0] && sign_a_r) fix_hi_s = neg_w(rem_r);
      else                      fix_hi_s = rem_r;
    end else begin
      if (!op_r[0] && (sign_a_r ^ sign_b_r)) prod_s = neg_p({rem_r, quo_r});
      else                                   prod_s = {rem_r, quo_r};
      fix_hi_s = prod_s[PW-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Operand capture, iteration, result write-back and HI/LO moves.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      op_r     <= 2'b00;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      mag_b_r  <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            op_r     <= op;
            sign_a_r <= !op[0] && src_a[WIDTH-1];
            sign_b_r <= !op[0] && src_b[WIDTH-1];
            b_zero_r <= (src_b == {WIDTH{1'b0}});
            mag_b_r  <= mag(src_b, !op[0]);
            quo_r    <= mag(src_a, !op[0]);
            rem_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end else if (mreg_we_s) begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        CALC: begin
          if (!flush) begin
            rem_r <= iter_rem_s;
            quo_r <= iter_quo_s;
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi_r   <= fix_hi_s;
            lo_r   <= fix_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign stall_req = busy_r;
  assign done      = done_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, stall8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) u_dut (
    .CLK(clk), .Reset(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .Reset(rst_n), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(busy8), .stall_req(stall8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at the negedge of cycle k0; waits for done, checking busy throughout.
  task automatic wait_done(input int k0, input int exp_lat, input string name);
    int k; int bad; bit seen;
    k = k0; bad = 0; seen = 1'b0;
    while (!seen && k <= exp_lat + 20) begin
      if (done) seen = 1'b1;
      else begin
        if (busy !== 1'b1 || stall_req !== 1'b1) bad++;
        @(negedge clk);
        k++;
      end
    end
    check({name, "_busy_window"}, 64'(bad), 64'd0);
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  // Launch at the current negedge (cycle 0) and check the result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 34, name);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic do_op8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el, input string name);
    int k;
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'd10);
    check({name, "_hi"}, 64'(hi8), 64'(eh));
    check({name, "_lo"}, 64'(lo8), 64'(el));
  endtask

  vec_t tbl[9];

  initial begin
    logic [63:0] exp;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int dcount;

    tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[4] = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
    model_hi = 32'd0; model_lo = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // mthi / mtlo / both
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi_lo", 64'(lo), 64'd0);
    check("mthi_no_done", 64'(done), 64'd0);
    lo_we = 1'b1; wdata = 32'h3C3C_3C3C;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, 64'hA5A5_A5A5_3C3C_3C3C);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both", {hi, lo}, 64'h1111_2222_1111_2222);
    model_hi = 32'h1111_2222; model_lo = 32'h1111_2222;

    // Directed vectors, issued back-to-back (start in each done cycle).
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    // Strobes and a second start while busy are ignored.
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    check("busy_write_ignored", {hi, lo}, {model_hi, model_lo});
    wait_done(6, 34, "busy_start");
    check("busy_start_result", {hi, lo}, {32'd2, 32'd14});
    model_hi = 32'd2; model_lo = 32'd14;
    @(negedge clk);

    // Flush at cycle 10, then start+flush, then a clean start.
    start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_drop", 64'(busy), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_no_launch", 64'(busy), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dcount), 64'd0);
    check("flush_hilo_kept", {hi, lo}, {model_hi, model_lo});
    do_op(2'b00, 32'd5, 32'd9, 32'd0, 32'd45, "after_flush");
    @(negedge clk);

    // Random operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      exp = ref_model(ro, ra, rb);
      do_op(ro, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d_op%0d", i, ro));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midreset_stays_idle", 64'(dcount), 64'd0);

    // Narrow instance.
    do_op8(2'b00, 8'hFD, 8'h07, 8'hFF, 8'hEB, "w8_mult");
    do_op8(2'b10, 8'hF9, 8'h02, 8'hFF, 8'hFD, "w8_div");
    do_op8(2'b11, 8'h64, 8'h00, 8'h64, 8'hFF, "w8_divu0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
